// File: rtl/band_scale_seq.sv
// Time-multiplexed equalizer band gain: each band's audio is scaled by the square of its pot.
// A single squarer and a single 13x16 multiplier are shared across all bands in sequence.
module band_scale_seq #(
   parameter int NUM_BANDS = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld,
   input  logic [12*NUM_BANDS-1:0]  pot,
   input  logic [16*NUM_BANDS-1:0]  audio,
   output logic [16*NUM_BANDS-1:0]  scaled,
   output logic [15:0]              eq_out,
   output logic                     out_vld,
   output logic                     busy,
   output logic                     overrun
);

   typedef enum logic [1:0] {IDLE, SQ, SC, DONE} state_t;

   state_t                    state;
   logic [2:0]                band;
   logic [12*NUM_BANDS-1:0]   pot_cap;
   logic [16*NUM_BANDS-1:0]   audio_cap;
   logic [16*NUM_BANDS-1:0]   work;
   logic [11:0]               sq_p0;

   logic [11:0]               pot_sel;
   logic signed [15:0]        aud_sel;
   logic [11:0]               sq_hi;
   logic signed [12:0]        coef;
   logic signed [28:0]        prod;
   logic signed [18:0]        sum;

   function automatic logic [15:0] sat_prod(input logic signed [28:0] p);
      if (p[28:25] == 4'b0000 || p[28:25] == 4'b1111)
         return p[25:10];
      else if (!p[28])
         return 16'h7FFF;
      else
         return 16'h8000;
   endfunction

   function automatic logic [15:0] sat_sum(input logic signed [18:0] s);
      if (s > 19'sd32767)
         return 16'h7FFF;
      else if (s < -19'sd32768)
         return 16'h8000;
      else
         return s[15:0];
   endfunction

   // Shared squarer: only the top 12 bits of the 24-bit square feed the scaler
   assign pot_sel = pot_cap[12*int'(band) +: 12];
   assign sq_hi   = 12'((24'(pot_sel) * 24'(pot_sel)) >> 12);

   // Shared multiplier: positive 13-bit gain times signed band audio
   assign aud_sel = $signed(audio_cap[16*int'(band) +: 16]);
   assign coef    = $signed({1'b0, sq_p0});
   assign prod    = coef * aud_sel;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_BANDS; i++)
         sum = sum + 19'($signed(work[16*i +: 16]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         band      <= '0;
         pot_cap   <= '0;
         audio_cap <= '0;
         work      <= '0;
         sq_p0     <= '0;
         scaled    <= '0;
         eq_out    <= '0;
         out_vld   <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_vld <= 1'b0;
         overrun <= 1'b0;
         case (state)
            IDLE: begin
               if (vld) begin
                  pot_cap   <= pot;
                  audio_cap <= audio;
                  band      <= '0;
                  busy      <= 1'b1;
                  state     <= SQ;
               end
            end
            SQ: begin
               sq_p0   <= sq_hi;
               overrun <= vld;
               state   <= SC;
            end
            SC: begin
               work[16*int'(band) +: 16] <= sat_prod(prod);
               overrun <= vld;
               if (band == 3'(NUM_BANDS - 1)) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  band  <= band + 3'd1;
                  state <= SQ;
               end
            end
            DONE: begin
               // Publish all bands and the sum together on one edge
               scaled  <= work;
               eq_out  <= sat_sum(sum);
               out_vld <= 1'b1;
               if (vld) begin
                  pot_cap   <= pot;
                  audio_cap <= audio;
                  band      <= '0;
                  busy      <= 1'b1;
                  state     <= SQ;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
